core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the sequential RV32I core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
- Owns the instruction/data memory request handshakes.
- Generates the write enables and mux selects for the instruction register, PC, register file and write-back path. The decode stage and ALU stay purely datapath.

Parameters:
- TIMEOUT, 255, maximum cycles to wait for a memory ack before entering FAULT.
- TO_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; reset rst, asynchronous, active-high
- rst  in  1  asynchronous active-high reset
- run  in  1  enables starting a new instruction
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- branch_taken  in  1  branch compare result from the ALU, valid in EXECUTE
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ack  in  1  data access complete
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  00 = pc+4, 01 = pc+imm, 10 = (rs1+imm)&~1
- rf_we  out  1  register file write enable (decode stage suppresses x0)
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = pc+4
- instr_retired  out  1  one-cycle pulse on an instruction's final cycle
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- state  out  3  current state encoding, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, FAULT=7.
- State and the latched opcode class are registered. All outputs are combinational from state, the latched class and the ack inputs.
- Reset: state=IDLE, timeout counter=0, class=0. Every output reads 0, including state=0. A reset mid-instruction aborts immediately with no further pulses.
- IDLE: run=1 moves to FETCH next cycle.
- FETCH: imem_req=1 held until imem_ack. In the ack cycle, ir_we=1 and the next state is DECODE.
- DECODE (1 cycle): opcode is latched into a class register.
  - Legal opcodes: 0110011 R, 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 1110011 SYSTEM.
  - SYSTEM goes to HALT. Any other unlisted opcode goes to FAULT. Everything else goes to EXECUTE.
- EXECUTE (1 cycle):
  - LOAD/STORE go to MEM.
  - BRANCH: pc_we=1, pc_sel = branch_taken ? 01 : 00, instr_retired=1, then END.
  - All other classes go to WB.
- MEM: dmem_req=1, with dmem_we=1 for STORE, held until dmem_ack.
  - On ack, LOAD goes to WB.
  - On ack, STORE asserts pc_we=1, pc_sel=00, instr_retired=1, then END.
- WB (1 cycle): rf_we=1, pc_we=1, instr_retired=1, then END.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
- END: go to FETCH if run=1, else IDLE. Deasserting run mid-instruction never truncates the instruction.
- HALT and FAULT: absorbing until rst. No requests or enables are asserted in either state.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When count==TIMEOUT with no ack, the next state is FAULT and the request drops.
  - An ack in the same cycle as count==TIMEOUT wins; no fault is raised.
- Acks arriving outside FETCH/MEM are ignored.
- Request stability: imem_req/dmem_req never drop before ack except on timeout or rst.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- Defined:
  - Two additional ports: cycle_count out 32 and instret_count out 32. Both reset to 0.
  - cycle_count increments every cycle outside IDLE, HALT and FAULT.
  - instret_count increments on each instr_retired pulse.
  - Both wrap from 0xFFFFFFFF to 0.
- Not defined: the ports and counters are absent.

Test Plan:
- R-type (opcode 0110011), imem_ack 2 cycles after req, run=1 -> states 1,1,1,2,3,5,1. ir_we on the ack cycle; rf_we=pc_we=instr_retired=1 in WB with wb_sel=00, pc_sel=00. 5 cycles from first req to WB.
- LOAD then STORE, dmem_ack after 3 cycles each -> LOAD: dmem_we=0, WB with wb_sel=01. STORE: dmem_we=1, no rf_we; pc_we on the ack cycle.
- BRANCH with branch_taken=1, then with branch_taken=0 -> pc_sel=01, then 00, in EXECUTE. No WB state and rf_we never asserted.
- JAL, then JALR -> WB with wb_sel=10 and pc_sel=01, then 10. Opcode 0000000 -> FAULT after DECODE, fault=1 held. 1110011 -> halted=1 held.
- TIMEOUT=4, imem_ack never asserted -> imem_req high 5 cycles, then FAULT. Repeat with ack on the 5th cycle -> DECODE, no fault. Drop run during MEM -> instruction retires, then IDLE.
- rst asserted asynchronously mid-MEM -> all outputs 0 immediately and state=IDLE. With PERF_COUNTERS_EN defined: counters return to 0, and 3 instructions give instret_count=3.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the sequential RV32I core.
// Each instruction moves through FETCH, DECODE, EXECUTE, MEM and WB. This
// block owns the instruction and data memory handshakes and generates the
// write enables and mux selects for the IR, PC, register file and
// write-back path.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   run                      allow a new instruction to start
//   opcode[6:0]              instr[6:0] from the IR (valid from DECODE on)
//   branch_taken             ALU branch compare result (valid in EXECUTE)
//   imem_req / imem_ack      instruction fetch handshake
//   dmem_req / dmem_we /     data access handshake (dmem_we: 1 = store)
//   dmem_ack
//   ir_we, pc_we, pc_sel     IR load, PC update, PC source
//                            (00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1)
//   rf_we, wb_sel            register write, write-back source
//                            (00 ALU, 01 memory, 10 pc+4)
//   instr_retired            one-cycle pulse on an instruction's last cycle
//   halted, fault            HALT / FAULT status
//   state[2:0]               current state, for debug
//
// Optional build macro PERF_COUNTERS_EN adds cycle_count[31:0] and
// instret_count[31:0] performance counters.
//
// Outputs are combinational from state, latched opcode class and the ack
// inputs (plus branch_taken for the branch PC select).

module core_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       instr_retired,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_FAULT   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_NONE    = 4'd0,
    C_R       = 4'd1,
    C_OPIMM   = 4'd2,
    C_LOAD    = 4'd3,
    C_STORE   = 4'd4,
    C_BRANCH  = 4'd5,
    C_JAL     = 4'd6,
    C_JALR    = 4'd7,
    C_LUI     = 4'd8,
    C_AUIPC   = 4'd9,
    C_SYSTEM  = 4'd10,
    C_ILLEGAL = 4'd11
  } cls_e;

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d;
  cls_e            dec_cls;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_hit;
  state_e          end_state;

  // Opcode to instruction class.
  always_comb begin
    dec_cls = C_ILLEGAL;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1110011: dec_cls = C_SYSTEM;
      default:    dec_cls = C_ILLEGAL;
    endcase
  end

  assign to_hit    = (cnt_q == TO_W'(TIMEOUT));
  // Where an instruction goes after its final cycle.
  assign end_state = run ? S_FETCH : S_IDLE;

  // Next state, timeout counter and control outputs.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cnt_d         = '0;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'b00;
    rf_we         = 1'b0;
    wb_sel        = 2'b00;
    instr_retired = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          C_SYSTEM:  state_d = S_HALT;
          C_ILLEGAL: state_d = S_FAULT;
          default:   state_d = S_EXECUTE;
        endcase
      end

      S_EXECUTE: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_we         = 1'b1;
            pc_sel        = branch_taken ? 2'b01 : 2'b00;
            instr_retired = 1'b1;
            state_d       = end_state;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_d       = end_state;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_WB: begin
        rf_we         = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        case (cls_q)
          C_LOAD:  wb_sel = 2'b01;
          C_JAL:   begin wb_sel = 2'b10; pc_sel = 2'b01; end
          C_JALR:  begin wb_sel = 2'b10; pc_sel = 2'b10; end
          default: wb_sel = 2'b00;
        endcase
        state_d = end_state;
      end

      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end

  assign state = 3'(state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instret_count_q, instret_count_d;

  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_comb begin
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;
    if (!(state_q inside {S_IDLE, S_HALT, S_FAULT}))
      cycle_count_d = cycle_count_q + 32'd1;
    if (instr_retired)
      instret_count_d = instret_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q   <= '0;
      instret_count_q <= '0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed testbench for core_sequencer (built with TIMEOUT=4).
// Output vector layout (obs):
//   [15] imem_req [14] ir_we [13] dmem_req [12] dmem_we [11] pc_we
//   [10:9] pc_sel [8] rf_we [7:6] wb_sel [5] instr_retired
//   [4] halted [3] fault [2:0] state
// Stimulus word per cycle: {opcode[6:0], run, imem_ack, dmem_ack, branch_taken}

module tb_core_sequencer;

  localparam logic [15:0] IREQ   = 16'h8000;
  localparam logic [15:0] IRWE   = 16'h4000;
  localparam logic [15:0] DREQ   = 16'h2000;
  localparam logic [15:0] DWE    = 16'h1000;
  localparam logic [15:0] PWE    = 16'h0800;
  localparam logic [15:0] PS_JR  = 16'h0400;
  localparam logic [15:0] PS_IMM = 16'h0200;
  localparam logic [15:0] RWE    = 16'h0100;
  localparam logic [15:0] WB_PC4 = 16'h0080;
  localparam logic [15:0] WB_MEM = 16'h0040;
  localparam logic [15:0] RET    = 16'h0020;
  localparam logic [15:0] HLT    = 16'h0010;
  localparam logic [15:0] FLT    = 16'h0008;

  localparam logic [15:0] ST_IDLE  = 16'd0;
  localparam logic [15:0] ST_FETCH = 16'd1;
  localparam logic [15:0] ST_DEC   = 16'd2;
  localparam logic [15:0] ST_EXE   = 16'd3;
  localparam logic [15:0] ST_MEM   = 16'd4;
  localparam logic [15:0] ST_WB    = 16'd5;
  localparam logic [15:0] ST_HALT  = 16'd6;
  localparam logic [15:0] ST_FAULT = 16'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic [1:0] pc_sel, wb_sel;
  logic       instr_retired, halted, fault;
  logic [2:0] state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int checks   = 0;
  int failures = 0;

  wire [15:0] obs = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we,
                     wb_sel, instr_retired, halted, fault, state};

  core_sequencer #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .rf_we         (rf_we),
    .wb_sel        (wb_sel),
    .instr_retired (instr_retired),
    .halted        (halted),
    .fault         (fault),
    .state         (state)
`ifdef PERF_COUNTERS_EN
    ,
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
`endif
  );

  always #5 clk = ~clk;

  // Reset pulse; returns 1ns after a rising edge with the DUT in IDLE.
  task automatic do_reset();
    {opcode, run, imem_ack, dmem_ack, branch_taken} = 11'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {opcode, run, imem_ack, dmem_ack, branch_taken} = {OP_R, 4'b1111};
    #2;
    if (obs !== 16'h0000) begin
      failures++;
      $display("FAIL reset_initial: got %h expected %h", obs, 16'h0000);
    end
    checks++;
    repeat (2) @(posedge clk);
    #1;
    if (obs !== 16'h0000) begin
      failures++;
      $display("FAIL reset_held: got %h expected %h", obs, 16'h0000);
    end
    checks++;
`ifdef PERF_COUNTERS_EN
    if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instret_count);
    end
    checks++;
`endif
    do_reset();
  endtask

  task automatic test_rtype();
    logic [10:0] stim [8];
    logic [15:0] expv [8];
    do_reset();
    stim[0] = {OP_R, 4'b1000}; expv[0] = ST_IDLE;
    stim[1] = {OP_R, 4'b1000}; expv[1] = IREQ | ST_FETCH;
    stim[2] = {OP_R, 4'b1000}; expv[2] = IREQ | ST_FETCH;
    stim[3] = {OP_R, 4'b1100}; expv[3] = IREQ | IRWE | ST_FETCH;
    stim[4] = {OP_R, 4'b1000}; expv[4] = ST_DEC;
    stim[5] = {OP_R, 4'b1000}; expv[5] = ST_EXE;
    stim[6] = {OP_R, 4'b1000}; expv[6] = PWE | RWE | RET | ST_WB;
    stim[7] = {OP_R, 4'b1000}; expv[7] = IREQ | ST_FETCH;
    for (int i = 0; i < 8; i++) begin
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL rtype cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    logic [10:0] stim [17];
    logic [15:0] expv [17];
    do_reset();
    stim[0]  = {OP_LOAD,  4'b1000}; expv[0]  = ST_IDLE;
    stim[1]  = {OP_LOAD,  4'b1100}; expv[1]  = IREQ | IRWE | ST_FETCH;
    stim[2]  = {OP_LOAD,  4'b1000}; expv[2]  = ST_DEC;
    stim[3]  = {OP_LOAD,  4'b1000}; expv[3]  = ST_EXE;
    stim[4]  = {OP_LOAD,  4'b1000}; expv[4]  = DREQ | ST_MEM;
    stim[5]  = {OP_LOAD,  4'b1000}; expv[5]  = DREQ | ST_MEM;
    stim[6]  = {OP_LOAD,  4'b1000}; expv[6]  = DREQ | ST_MEM;
    stim[7]  = {OP_LOAD,  4'b1010}; expv[7]  = DREQ | ST_MEM;
    stim[8]  = {OP_LOAD,  4'b1000}; expv[8]  = PWE | RWE | WB_MEM | RET | ST_WB;
    stim[9]  = {OP_STORE, 4'b1100}; expv[9]  = IREQ | IRWE | ST_FETCH;
    stim[10] = {OP_STORE, 4'b1000}; expv[10] = ST_DEC;
    stim[11] = {OP_STORE, 4'b1000}; expv[11] = ST_EXE;
    stim[12] = {OP_STORE, 4'b1000}; expv[12] = DREQ | DWE | ST_MEM;
    stim[13] = {OP_STORE, 4'b1000}; expv[13] = DREQ | DWE | ST_MEM;
    stim[14] = {OP_STORE, 4'b1000}; expv[14] = DREQ | DWE | ST_MEM;
    stim[15] = {OP_STORE, 4'b0010}; expv[15] = DREQ | DWE | PWE | RET | ST_MEM;
    stim[16] = {OP_STORE, 4'b0000}; expv[16] = ST_IDLE;
    for (int i = 0; i < 17; i++) begin
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL load_store cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [10:0] stim [8];
    logic [15:0] expv [8];
    do_reset();
    stim[0] = {OP_BR, 4'b1000}; expv[0] = ST_IDLE;
    stim[1] = {OP_BR, 4'b1100}; expv[1] = IREQ | IRWE | ST_FETCH;
    stim[2] = {OP_BR, 4'b1000}; expv[2] = ST_DEC;
    stim[3] = {OP_BR, 4'b1001}; expv[3] = PWE | PS_IMM | RET | ST_EXE;
    stim[4] = {OP_BR, 4'b1100}; expv[4] = IREQ | IRWE | ST_FETCH;
    stim[5] = {OP_BR, 4'b1000}; expv[5] = ST_DEC;
    stim[6] = {OP_BR, 4'b0000}; expv[6] = PWE | RET | ST_EXE;
    stim[7] = {OP_BR, 4'b0001}; expv[7] = ST_IDLE;
    for (int i = 0; i < 8; i++) begin
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL branch cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    logic [10:0] stim [10];
    logic [15:0] expv [10];
    do_reset();
    stim[0] = {OP_JAL,  4'b1000}; expv[0] = ST_IDLE;
    stim[1] = {OP_JAL,  4'b1100}; expv[1] = IREQ | IRWE | ST_FETCH;
    stim[2] = {OP_JAL,  4'b1000}; expv[2] = ST_DEC;
    stim[3] = {OP_JAL,  4'b1000}; expv[3] = ST_EXE;
    stim[4] = {OP_JAL,  4'b1000}; expv[4] = PWE | PS_IMM | RWE | WB_PC4 | RET | ST_WB;
    stim[5] = {OP_JALR, 4'b1100}; expv[5] = IREQ | IRWE | ST_FETCH;
    stim[6] = {OP_JALR, 4'b1000}; expv[6] = ST_DEC;
    stim[7] = {OP_JALR, 4'b1000}; expv[7] = ST_EXE;
    stim[8] = {OP_JALR, 4'b0000}; expv[8] = PWE | PS_JR | RWE | WB_PC4 | RET | ST_WB;
    stim[9] = {OP_JALR, 4'b0000}; expv[9] = ST_IDLE;
    for (int i = 0; i < 10; i++) begin
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL jumps cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  // Illegal opcode to FAULT, SYSTEM to HALT; both absorb acks and run.
  task automatic test_fault_halt();
    logic [10:0] stim [12];
    logic [15:0] expv [12];
    stim[0]  = {OP_BAD, 4'b1000}; expv[0]  = ST_IDLE;
    stim[1]  = {OP_BAD, 4'b1100}; expv[1]  = IREQ | IRWE | ST_FETCH;
    stim[2]  = {OP_BAD, 4'b1000}; expv[2]  = ST_DEC;
    stim[3]  = {OP_BAD, 4'b1111}; expv[3]  = FLT | ST_FAULT;
    stim[4]  = {OP_R,   4'b1110}; expv[4]  = FLT | ST_FAULT;
    stim[5]  = {OP_R,   4'b0000}; expv[5]  = FLT | ST_FAULT;
    stim[6]  = {OP_SYS, 4'b1000}; expv[6]  = ST_IDLE;
    stim[7]  = {OP_SYS, 4'b1100}; expv[7]  = IREQ | IRWE | ST_FETCH;
    stim[8]  = {OP_SYS, 4'b1000}; expv[8]  = ST_DEC;
    stim[9]  = {OP_SYS, 4'b1111}; expv[9]  = HLT | ST_HALT;
    stim[10] = {OP_R,   4'b1110}; expv[10] = HLT | ST_HALT;
    stim[11] = {OP_R,   4'b0000}; expv[11] = HLT | ST_HALT;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 6) do_reset();
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL fault_halt cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  // TIMEOUT=4: five request cycles then FAULT; ack on the fifth cycle wins.
  task automatic test_timeout();
    logic [10:0] stim [16];
    logic [15:0] expv [16];
    stim[0]  = {OP_R, 4'b1000}; expv[0]  = ST_IDLE;
    stim[1]  = {OP_R, 4'b1000}; expv[1]  = IREQ | ST_FETCH;
    stim[2]  = {OP_R, 4'b1000}; expv[2]  = IREQ | ST_FETCH;
    stim[3]  = {OP_R, 4'b1000}; expv[3]  = IREQ | ST_FETCH;
    stim[4]  = {OP_R, 4'b1000}; expv[4]  = IREQ | ST_FETCH;
    stim[5]  = {OP_R, 4'b1000}; expv[5]  = IREQ | ST_FETCH;
    stim[6]  = {OP_R, 4'b1100}; expv[6]  = FLT | ST_FAULT;
    stim[7]  = {OP_R, 4'b1000}; expv[7]  = FLT | ST_FAULT;
    stim[8]  = {OP_R, 4'b1000}; expv[8]  = ST_IDLE;
    stim[9]  = {OP_R, 4'b1000}; expv[9]  = IREQ | ST_FETCH;
    stim[10] = {OP_R, 4'b1000}; expv[10] = IREQ | ST_FETCH;
    stim[11] = {OP_R, 4'b1000}; expv[11] = IREQ | ST_FETCH;
    stim[12] = {OP_R, 4'b1000}; expv[12] = IREQ | ST_FETCH;
    stim[13] = {OP_R, 4'b1100}; expv[13] = IREQ | IRWE | ST_FETCH;
    stim[14] = {OP_R, 4'b1000}; expv[14] = ST_DEC;
    stim[15] = {OP_R, 4'b1000}; expv[15] = ST_EXE;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 8) do_reset();
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run_drop();
    logic [10:0] stim [9];
    logic [15:0] expv [9];
    do_reset();
    stim[0] = {OP_LOAD, 4'b1000}; expv[0] = ST_IDLE;
    stim[1] = {OP_LOAD, 4'b1100}; expv[1] = IREQ | IRWE | ST_FETCH;
    stim[2] = {OP_LOAD, 4'b1000}; expv[2] = ST_DEC;
    stim[3] = {OP_LOAD, 4'b1000}; expv[3] = ST_EXE;
    stim[4] = {OP_LOAD, 4'b0000}; expv[4] = DREQ | ST_MEM;
    stim[5] = {OP_LOAD, 4'b0010}; expv[5] = DREQ | ST_MEM;
    stim[6] = {OP_LOAD, 4'b0000}; expv[6] = PWE | RWE | WB_MEM | RET | ST_WB;
    stim[7] = {OP_LOAD, 4'b0110}; expv[7] = ST_IDLE;
    stim[8] = {OP_LOAD, 4'b0000}; expv[8] = ST_IDLE;
    for (int i = 0; i < 9; i++) begin
      {opcode, run, imem_ack, dmem_ack, branch_taken} = stim[i];
      #1;
      if (obs !== expv[i]) begin
        failures++;
        $display("FAIL run_drop cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted between clock edges while in MEM.
  task automatic test_async_reset();
    do_reset();
    {opcode, run, imem_ack, dmem_ack, branch_taken} = {OP_LOAD, 4'b1000};
    @(posedge clk); #1;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (obs !== (DREQ | ST_MEM)) begin
      failures++;
      $display("FAIL async_reset_pre: got %h expected %h", obs, DREQ | ST_MEM);
    end
    checks++;
    #2;
    rst = 1'b1;
    dmem_ack = 1'b1;
    #1;
    if (obs !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset_now: got %h expected %h", obs, 16'h0000);
    end
    checks++;
`ifdef PERF_COUNTERS_EN
    if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_counters: got %0d/%0d expected 0/0", cycle_count, instret_count);
    end
    checks++;
`endif
    @(posedge clk); #1;
    if (obs !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset_held: got %h expected %h", obs, 16'h0000);
    end
    checks++;
    do_reset();
  endtask

`ifdef PERF_COUNTERS_EN
  // Three back-to-back R-type instructions: 12 active cycles, 3 retired.
  task automatic test_perf_counters();
    do_reset();
    {opcode, run, imem_ack, dmem_ack, branch_taken} = {OP_R, 4'b1000};
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      run = (k < 2);
      @(posedge clk); #1;
    end
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL perf_state: got %0d expected 0", state);
    end
    checks++;
    if (cycle_count !== 32'd12) begin
      failures++;
      $display("FAIL perf_cycle_count: got %0d expected 12", cycle_count);
    end
    checks++;
    if (instret_count !== 32'd3) begin
      failures++;
      $display("FAIL perf_instret_count: got %0d expected 3", instret_count);
    end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch();
    test_jumps();
    test_fault_halt();
    test_timeout();
    test_run_drop();
    test_async_reset();
`ifdef PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
